soc_sysid_checker: RTL and testbench

SOC_SYSID_CHECKER -- requirements
Module: soc_sysid_checker

---
 rtl/soc_sysid_checker.sv | 220 ++++++++++++++++++++++
 tb/tb_soc_sysid_checker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_sysid_checker.sv
// -----------------------------------------------------------------------------
// soc_sysid_checker
//
// Purpose:
//   Reads the two words of an Avalon-MM system-ID slave (word 0 = system ID,
//   word 1 = build timestamp) on request. It then compares them against the
//   values this build was compiled for and reports the result.
//
// Ports:
//   clock            in   single clock domain, rising edge
//   reset_n          in   asynchronous active-low reset
//   start            in   one-cycle request to run a check (only seen in IDLE)
//   avm_address      out  word address to the sysid slave (0 = ID, 1 = TS)
//   avm_read         out  Avalon-MM read strobe
//   avm_readdata     in   [31:0] slave read data
//   avm_waitrequest  in   slave stall
//   busy             out  FSM is not in IDLE
//   done             out  one-cycle completion pulse
//   id_value         out  [31:0] captured system ID word
//   ts_value         out  [31:0] captured timestamp word
//   id_ok            out  id_value matched EXPECTED_ID (held until next start)
//   ts_ok            out  ts_value matched EXPECTED_TS (held until next start)
//   timeout          out  a read stalled for TIMEOUT_CYCLES cycles
//   dbg_state        out  [1:0] current FSM state, for observation
//
// Handshake:
//   A read word is accepted in any cycle where avm_read=1 and
//   avm_waitrequest=0. While avm_read=1 and avm_waitrequest=1, avm_address
//   and avm_read hold. The stall timeout is the only exception: it drops
//   avm_read.
//
// Configuration:
//   SOC_SYSID_CHECK_TIMEOUT_EN - when defined, adds a 16-bit stall counter.
//   A read that stalls for TIMEOUT_CYCLES cycles is abandoned. The block then
//   flags timeout, clears both ok flags and still pulses done. When
//   undefined, timeout is tied 0 and a read may stall forever.
// -----------------------------------------------------------------------------
module soc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h08001030,
  parameter logic [31:0] EXPECTED_TS    = 32'h69450724,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [1:0]  dbg_state
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("soc_sysid_checker: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RD_ID  = 2'd1,
    ST_RD_TS  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        done_q, done_d;

  // stall_abort: the current read has reached its stall limit this cycle.
  // tmo_flag:    the transaction in flight was abandoned on a stall.
  logic        stall_abort;
  logic        tmo_flag;

  // Bus strobes decode straight from the state register. This lets reset
  // drop them immediately, and keeps the address stable for the whole read.
  assign avm_read    = (state_q == ST_RD_ID) || (state_q == ST_RD_TS);
  assign avm_address = (state_q == ST_RD_TS);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = tmo_flag;
  assign dbg_state   = state_q;

`ifdef SOC_SYSID_CHECK_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_cnt_inc;

  assign stall_cnt_inc = stall_cnt_q + 16'd1;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;
    stall_abort = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start) begin
        // Entering RD_ID: fresh count, and the previous verdict is dropped.
        stall_cnt_d = '0;
        timeout_d   = 1'b0;
      end
    end else if (avm_read) begin
      if (avm_waitrequest) begin
        stall_cnt_d = stall_cnt_inc;
        // The limit is inclusive: this stalled cycle brings the count to
        // TIMEOUT_CYCLES, so the read is abandoned at this edge.
        if (stall_cnt_inc >= TMO_LIMIT) begin
          stall_abort = 1'b1;
          timeout_d   = 1'b1;
        end
      end else begin
        // Word accepted: the next read state (RD_TS) starts from zero.
        stall_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign tmo_flag = timeout_q;
`else
  assign stall_abort = 1'b0;
  assign tmo_flag    = 1'b0;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    done_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RD_ID;
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
        end
      end

      ST_RD_ID: begin
        if (!avm_waitrequest) begin
          id_value_d = avm_readdata;
          state_d    = ST_RD_TS;
        end else if (stall_abort) begin
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          state_d = ST_FINISH;
        end
      end

      ST_RD_TS: begin
        if (!avm_waitrequest) begin
          ts_value_d = avm_readdata;
          state_d    = ST_FINISH;
        end else if (stall_abort) begin
          id_ok_d = 1'b0;
          ts_ok_d = 1'b0;
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        // An abandoned transaction keeps the cleared flags; the captured
        // words may be stale and must not be judged.
        if (!tmo_flag) begin
          id_ok_d = (id_value_q == EXPECTED_ID);
          ts_ok_d = (ts_value_q == EXPECTED_TS);
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      id_value_q <= 32'h0;
      ts_value_q <= 32'h0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_soc_sysid_checker.sv
// -----------------------------------------------------------------------------
// tb_soc_sysid_checker
//
// Testbench for soc_sysid_checker. It contains:
//   - a sysid slave model that serves the two words with a chosen number of
//     waitrequest cycles per read;
//   - a reference model that gives, for each transaction, the expected
//     latency (4 cycles plus every stall cycle), the captured words and the
//     ok flags;
//   - directed cases followed by randomized transactions.
// -----------------------------------------------------------------------------
module tb_soc_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h08001030;
  localparam logic [31:0] EXP_TS = 32'h69450724;
  localparam int          TMO    = 8;
  localparam int          BOUND  = 60;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_address, avm_read, busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;
  logic [1:0]  dbg_state;

  always #5 clock = ~clock;

  soc_sysid_checker #(
    .EXPECTED_ID   (EXP_ID),
    .EXPECTED_TS   (EXP_TS),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .done           (done),
    .id_value       (id_value),
    .ts_value       (ts_value),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout        (timeout),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  logic [31:0] slave_word[2];
  int          rem_stall[2];
  logic        prev_stalled = 1'b0;
  logic        prev_addr = 1'b0;

  // React within the current cycle to the strobes the DUT presents.
  task automatic slave_drive();
    int a;
    if (avm_read === 1'b1) begin
      a = (avm_address === 1'b1) ? 1 : 0;
      avm_readdata = slave_word[a];
      if (rem_stall[a] > 0) begin
        avm_waitrequest = 1'b1;
        rem_stall[a]--;
      end else begin
        avm_waitrequest = 1'b0;
      end
    end else begin
      avm_waitrequest = 1'b0;
      avm_readdata    = 32'h0;
    end
    prev_stalled = (avm_read === 1'b1) && avm_waitrequest;
    prev_addr    = avm_address;
  endtask

  // One clock: sample 1 time unit after the rising edge, then react.
  task automatic tick();
    logic was_stalled;
    logic was_addr;
    was_stalled = prev_stalled;
    was_addr    = prev_addr;
    @(posedge clock);
    #1;
    if (was_stalled && avm_read === 1'b1)
      check_eq("addr_stable", {31'h0, avm_address}, {31'h0, was_addr});
    slave_drive();
  endtask

  // ---------------- driver ----------------
  task automatic run_txn(input logic [31:0] id_w, input logic [31:0] ts_w,
                         input int s_id, input int s_ts, input bit repulse);
    int edges;
    int pulses;
    slave_word[0] = id_w;
    slave_word[1] = ts_w;
    rem_stall[0]  = s_id;
    rem_stall[1]  = s_ts;
    exp_q.push_back(id_w);
    exp_q.push_back(ts_w);
    exp_q.push_back({31'h0, id_w == EXP_ID});
    exp_q.push_back({31'h0, ts_w == EXP_TS});
    exp_q.push_back(32'(4 + s_id + s_ts));

    check_eq("idle_read", {31'h0, avm_read}, 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    check_eq("busy_after_start", {31'h0, busy}, 32'h1);
    while (done !== 1'b1 && edges < BOUND) begin
      start = (repulse && edges == s_id + 2) ? 1'b1 : 1'b0;
      tick();
      edges++;
    end
    start = 1'b0;
    begin
      logic [31:0] e_id, e_ts, e_iok, e_tok, e_lat;
      e_id  = exp_q.pop_front();
      e_ts  = exp_q.pop_front();
      e_iok = exp_q.pop_front();
      e_tok = exp_q.pop_front();
      e_lat = exp_q.pop_front();
      if (done !== 1'b1) begin
        check_eq("done_seen", {31'h0, done}, 32'h1);
      end else begin
        check_eq("latency", 32'(edges), e_lat);
        check_eq("id_value", id_value, e_id);
        check_eq("ts_value", ts_value, e_ts);
        check_eq("id_ok", {31'h0, id_ok}, e_iok);
        check_eq("ts_ok", {31'h0, ts_ok}, e_tok);
        check_eq("timeout_clear", {31'h0, timeout}, 32'h0);
        check_eq("busy_at_done", {31'h0, busy}, 32'h0);
      end
    end
    // done is one cycle wide and a re-pulsed start launched nothing.
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done === 1'b1) pulses++;
      check_eq("busy_after", {31'h0, busy}, 32'h0);
    end
    check_eq("extra_done", 32'(pulses), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    slave_word[0] = 32'h0;
    slave_word[1] = 32'h0;
    rem_stall[0]  = 0;
    rem_stall[1]  = 0;

    #1 reset_n = 1'b0;
    tick();
    tick();
    check_eq("rst_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_done", {31'h0, done}, 32'h0);
    check_eq("rst_read", {31'h0, avm_read}, 32'h0);
    check_eq("rst_id_value", id_value, 32'h0);
    check_eq("rst_flags", {29'h0, id_ok, ts_ok, timeout}, 32'h0);
    reset_n = 1'b1;
    tick();
    tick();
    check_eq("idle_wait", {31'h0, busy}, 32'h0);

    // Directed cases.
    run_txn(EXP_ID, EXP_TS, 0, 0, 1'b0);
    run_txn(32'h08001031, EXP_TS, 0, 0, 1'b0);
    run_txn(EXP_ID, EXP_TS, 3, 3, 1'b0);
    run_txn(EXP_ID, 32'h12345678, 1, 2, 1'b1);

    // Reset while a stalled ID read is in flight.
    slave_word[0] = EXP_ID;
    slave_word[1] = EXP_TS;
    rem_stall[0]  = 6;
    rem_stall[1]  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_eq("pre_rst_read", {31'h0, avm_read}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("mid_rst_strobes", {30'h0, avm_read, avm_address}, 32'h0);
    check_eq("mid_rst_status", {29'h0, busy, done, timeout}, 32'h0);
    check_eq("mid_rst_flags", {30'h0, id_ok, ts_ok}, 32'h0);
    check_eq("mid_rst_id", id_value, 32'h0);
    check_eq("mid_rst_ts", ts_value, 32'h0);
    prev_stalled = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
        tick();
        if (done === 1'b1) pulses++;
      end
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (done === 1'b1) pulses++;
      end
      check_eq("rst_no_done", 32'(pulses), 32'h0);
      check_eq("rst_idle_wait", {31'h0, busy}, 32'h0);
    end
    run_txn(EXP_ID, EXP_TS, 0, 1, 1'b0);

    // Randomized transactions.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] id_w, ts_w;
      int mode;
      mode = $urandom_range(0, 3);
      id_w = EXP_ID;
      ts_w = EXP_TS;
      if (mode == 1) id_w = EXP_ID ^ (32'h1 << $urandom_range(0, 31));
      if (mode == 2) ts_w = $urandom;
      if (mode == 3) begin
        id_w = $urandom;
        ts_w = $urandom;
      end
      run_txn(id_w, ts_w, $urandom_range(0, 4), $urandom_range(0, 4),
              ($urandom_range(0, 2) == 0));
    end

`ifdef SOC_SYSID_CHECK_TIMEOUT_EN
    // Slave never releases waitrequest on the ID read.
    begin
      int edges;
      slave_word[0] = EXP_ID;
      slave_word[1] = EXP_TS;
      rem_stall[0]  = 100000;
      rem_stall[1]  = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      edges = 1;
      while (done !== 1'b1 && edges < BOUND) begin
        tick();
        edges++;
      end
      check_eq("tmo_done_seen", {31'h0, done}, 32'h1);
      check_eq("tmo_latency", 32'(edges), 32'(TMO + 2));
      check_eq("tmo_flag", {31'h0, timeout}, 32'h1);
      check_eq("tmo_ok_flags", {30'h0, id_ok, ts_ok}, 32'h0);
      for (int i = 0; i < 3; i++) begin
        tick();
        check_eq("tmo_read_low", {31'h0, avm_read}, 32'h0);
      end
      rem_stall[0] = 0;
    end
    run_txn(EXP_ID, EXP_TS, 0, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
